// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a one-byte holding register.
// Latency: o_rx_valid rises 154*(i_baud_div+1)+1 clocks after the start edge is seen on the synchronised line.
// Backpressure: one holding register; a byte completing while it is full and i_rx_ready is low is dropped and pulses o_overrun.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              receiver enable; low aborts any frame and forces IDLE
//   i_baud_div        oversample prescaler; one tick every i_baud_div+1 clocks, 16 ticks per bit
//   i_rx              asynchronous serial input, idle high
//   o_rx_data/o_rx_valid/i_rx_ready   received byte handshake
//   o_busy            FSM not in IDLE
//   o_frame_err       one-cycle pulse: stop bit sampled low
//   o_overrun         one-cycle pulse: completed byte dropped, holding register full
module uart_rx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_baud_div,
    input  logic                 i_rx,
    output logic [7:0]           o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_rx_m;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [3:0]           r_smp;
    logic [3:0]           r_bit;
    logic [7:0]           r_shreg;
    logic                 r_v7;
    logic                 r_v8;

    logic w_tick;
    logic w_decide;
    logic w_bit_end;
    logic w_vote;

    assign w_tick    = (r_state != S_IDLE) && (r_cnt == i_baud_div);
    // Bit value is decided on the third sample; the third vote is the live synchronised line.
    assign w_decide  = w_tick && (r_smp == 4'd9);
    assign w_bit_end = w_tick && (r_smp == 4'd15);
    assign w_vote    = (r_v7 & r_v8) | (r_v7 & r_rx_s) | (r_v8 & r_rx_s);

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    // All reset high so a reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_rx_m <= i_rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            o_busy      <= 1'b0;
            r_cnt       <= '0;
            r_smp       <= 4'd0;
            r_bit       <= 4'd0;
            r_shreg     <= 8'h00;
            r_v7        <= 1'b0;
            r_v8        <= 1'b0;
            o_rx_data   <= 8'h00;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // Consumer handshake; a delivery later in this block overrides the clear.
            if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end

            if (!i_en) begin
                // Abort without touching the holding register.
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == S_IDLE) begin
                r_cnt <= '0;
                // Requires a genuine high-to-low edge: a line stuck low never re-triggers.
                if (r_rx_d && !r_rx_s) begin
                    r_state <= S_START;
                    o_busy  <= 1'b1;
                    r_smp   <= 4'd0;
                    r_bit   <= 4'd0;
                end
            end else begin
                if (w_tick) begin
                    r_cnt <= '0;
                    r_smp <= r_smp + 4'd1;
                    if (r_smp == 4'd7) r_v7 <= r_rx_s;
                    if (r_smp == 4'd8) r_v8 <= r_rx_s;
                end else begin
                    r_cnt <= r_cnt + DIV_WIDTH'(1);
                end

                case (r_state)
                    S_START: begin
                        if (w_decide && w_vote) begin
                            // Start bit did not hold low through mid-bit: glitch.
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end else if (w_bit_end) begin
                            r_state <= S_DATA;
                            r_bit   <= 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_decide) begin
                            r_shreg <= {w_vote, r_shreg[7:1]};
                        end
                        if (w_bit_end) begin
                            r_bit <= r_bit + 4'd1;
                            if (r_bit == 4'd8) r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        // Finish at mid stop bit so a following start edge is never missed.
                        if (w_decide) begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                            r_cnt   <= '0;
                            if (w_vote) begin
                                if (!o_rx_valid || i_rx_ready) begin
                                    o_rx_data  <= r_shreg;
                                    o_rx_valid <= 1'b1;
                                end else begin
                                    o_overrun <= 1'b1;
                                end
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BP  = 64;   // clocks per bit with baud_div = 3
    localparam int LAT = 619;  // drive of start bit -> rx_valid: 2 sync clocks + D+617

    localparam int K_DATA = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b1;
    logic [15:0] i_baud_div = 16'd3;
    logic        i_rx = 1'b1;
    logic        i_rx_ready = 1'b1;
    logic [7:0]  o_rx_data;
    logic        o_rx_valid;
    logic        o_busy;
    logic        o_frame_err;
    logic        o_overrun;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic prev_v = 1'b0;

    uart_rx #(.DIV_WIDTH(16)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_baud_div (i_baud_div),
        .i_rx       (i_rx),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .i_rx_ready (i_rx_ready),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input logic [7:0] dat);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d data 0x%0h at cycle %0d, none expected", kind, dat, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == K_DATA && e.dat !== dat)) begin
                failures++;
                $display("FAIL event: got kind %0d data 0x%0h cycle %0d expected kind %0d data 0x%0h cycle %0d",
                         kind, dat, cyc, e.kind, e.dat, e.cyc);
            end
        end
    endtask

    // Monitor: sample just after each rising edge. i_rx_ready only changes on the
    // falling edge, so its current value is what the DUT saw at this rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (i_rst) begin
                prev_v = 1'b0;
            end else begin
                if (o_rx_valid && (!prev_v || i_rx_ready)) pop_check(K_DATA, o_rx_data);
                if (o_frame_err) pop_check(K_FERR, 8'h00);
                if (o_overrun)   pop_check(K_OVR, 8'h00);
                prev_v = o_rx_valid;
            end
        end
    end

    // Called just after a falling edge; drives the first n slots of a frame (start, d0..d7, stop).
    task automatic drive_bits(input logic [7:0] d, input logic stop, input int n);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            i_rx = bits[i];
            repeat (BP) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int kind);
        exp_t e;
        e.kind = kind;
        e.dat  = d;
        e.cyc  = cyc + LAT;
        q.push_back(e);
        drive_bits(d, stop, 10);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s;
        // Reset state
        repeat (5) @(negedge clk);
        chk("reset_rx_data", {24'h0, o_rx_data}, 32'h00);
        chk("reset_rx_valid", {31'h0, o_rx_valid}, 32'h0);
        chk("reset_busy", {31'h0, o_busy}, 32'h0);
        chk("reset_frame_err", {31'h0, o_frame_err}, 32'h0);
        chk("reset_overrun", {31'h0, o_overrun}, 32'h0);
        i_rst = 1'b0;
        idle(BP);

        // Single byte, ready held high: one valid cycle at D+617
        send_frame(8'hA5, 1'b1, K_DATA);
        idle(2 * BP);
        chk("single_valid_cleared", {31'h0, o_rx_valid}, 32'h0);
        chk("single_data_held", {24'h0, o_rx_data}, 32'hA5);

        // Glitch: 20-clock low pulse, busy goes high then back low
        i_rx = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_high", {31'h0, o_busy}, 32'h1);
        repeat (15) @(negedge clk);
        idle(60);
        chk("glitch_busy_low", {31'h0, o_busy}, 32'h0);
        idle(BP);

        // Framing error, then the line stays low: no new frame
        send_frame(8'h3C, 1'b0, K_FERR);
        repeat (3 * BP) @(negedge clk);
        chk("ferr_no_restart_low", {31'h0, o_busy}, 32'h0);
        chk("ferr_no_valid", {31'h0, o_rx_valid}, 32'h0);
        idle(2 * BP);

        // Overrun, back-to-back frames with one stop bit
        i_rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, K_DATA);
        send_frame(8'h22, 1'b1, K_OVR);
        idle(BP);
        chk("ovr_valid_held", {31'h0, o_rx_valid}, 32'h1);
        chk("ovr_data_held", {24'h0, o_rx_data}, 32'h11);
        i_rx_ready = 1'b1;
        @(negedge clk);
        i_rx_ready = 1'b0;
        @(negedge clk);
        chk("ovr_drained_valid", {31'h0, o_rx_valid}, 32'h0);
        chk("ovr_drained_data", {24'h0, o_rx_data}, 32'h11);
        idle(BP);

        // Ready exactly in the completion cycle of a new byte
        send_frame(8'h55, 1'b1, K_DATA);
        s = cyc;
        fork
            send_frame(8'hAA, 1'b1, K_DATA);
            begin
                repeat (LAT - 1) @(negedge clk);
                i_rx_ready = 1'b1;
                @(negedge clk);
                i_rx_ready = 1'b0;
            end
        join
        idle(BP);
        chk("simul_valid", {31'h0, o_rx_valid}, 32'h1);
        chk("simul_data", {24'h0, o_rx_data}, 32'hAA);
        chk("simul_start_ref", s + LAT - 1 > 0 ? 32'h1 : 32'h0, 32'h1);

        // Reset during data bit 4 with a byte pending
        drive_bits(8'h0F, 1'b1, 4);
        i_rx = 1'b1;
        repeat (BP / 2) @(negedge clk);
        chk("rstmid_busy_before", {31'h0, o_busy}, 32'h1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rstmid_rx_data", {24'h0, o_rx_data}, 32'h00);
        chk("rstmid_rx_valid", {31'h0, o_rx_valid}, 32'h0);
        chk("rstmid_busy", {31'h0, o_busy}, 32'h0);
        chk("rstmid_frame_err", {31'h0, o_frame_err}, 32'h0);
        chk("rstmid_overrun", {31'h0, o_overrun}, 32'h0);
        i_rst = 1'b0;
        i_rx_ready = 1'b1;
        idle(2 * BP);
        send_frame(8'hF0, 1'b1, K_DATA);
        idle(BP);

        // Enable dropped during data bit 4 with a byte pending
        i_rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, K_DATA);
        idle(BP);
        drive_bits(8'hC3, 1'b1, 4);
        i_rx = 1'b0;
        repeat (BP / 2) @(negedge clk);
        chk("enmid_busy_before", {31'h0, o_busy}, 32'h1);
        i_en = 1'b0;
        @(negedge clk);
        chk("enmid_busy", {31'h0, o_busy}, 32'h0);
        chk("enmid_valid_kept", {31'h0, o_rx_valid}, 32'h1);
        chk("enmid_data_kept", {24'h0, o_rx_data}, 32'h5A);
        idle(8 * BP);
        i_en = 1'b1;
        idle(4 * BP);
        chk("enmid_valid_late", {31'h0, o_rx_valid}, 32'h1);
        chk("enmid_data_late", {24'h0, o_rx_data}, 32'h5A);
        i_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("enmid_drained", {31'h0, o_rx_valid}, 32'h0);

        chk("all_events_seen", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the chip's UART. It de-serialises 8N1 frames arriving on the `URX` pad, which the bench UART master drives, into bytes. Each byte is presented on a valid/ready interface to the on-chip register/command logic. Framing errors and overruns are reported as single-cycle status pulses.

## Interface
- `DIV_WIDTH`, 16, width of the `baud_div` prescaler input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  receiver enable. Low forces IDLE and aborts any frame in flight.
- `baud_div`  in  DIV_WIDTH  oversample prescaler. One oversample tick occurs every `baud_div+1` clocks; one bit lasts 16 ticks.
- `rx`  in  1  serial input from the pad, asynchronous; idle level is high.
- `rx_data`  out  8  received byte, valid while `rx_valid` is high.
- `rx_valid`  out  1  holding register is full.
- `rx_ready`  in  1  consumer accepts the byte on a cycle where `rx_valid && rx_ready`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because the holding register is full.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, giving `rx_s`. Both flops reset to 1. A third flop, `rx_d`, is used for edge detection.
- **Prescaler:** `cnt` counts 0..`baud_div`. A tick is generated when `cnt==baud_div`, and `cnt` then returns to 0. `cnt` is held at 0 in IDLE.
- **Sample index:** `smp` is 4 bits and increments on every tick, wrapping 15->0. Bit index `bit` runs 0..9: 0 = start, 1..8 = data LSB first, 9 = stop.
- **Majority vote:** `rx_s` is captured on the ticks where `smp` is 7, 8 and 9. The bit value is the majority of the three, decided on the tick with `smp==9`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE -> START when `en && rx_d==1 && rx_s==0`, i.e. a falling edge. `cnt`, `smp` and `bit` are cleared to 0.
  - START: a vote of 1 is a false start and returns to IDLE. A vote of 0 continues; on the tick with `smp==15` the FSM moves to DATA with `bit=1`.
  - DATA: the vote is shifted into `shreg[7]` while `shreg` shifts right. On the `smp==15` tick, `bit` increments. After bit 8 the FSM moves to STOP.
  - STOP: this decision happens on the tick with `smp==9`, without waiting for the full bit, and the FSM always returns to IDLE.
    - A vote of 1 delivers `shreg` to the holding register.
    - A vote of 0 pulses `frame_err` and discards the byte.
- **Delivery rules:**
  - Holding register empty, or `rx_ready` high in the same cycle: load `rx_data`; `rx_valid` is 1 next cycle.
  - Holding register full and `rx_ready` low: pulse `overrun`; the new byte is dropped and `rx_data` is unchanged.
- **Handshake:** on `rx_valid && rx_ready` with no new delivery, `rx_valid` clears next cycle. `rx_data` holds its last value after clearing.
- **Line stuck low after a framing error or break:** no new START is taken until `rx_s` returns high and falls again.
- **`en` low:** the FSM goes to IDLE on the next cycle and no pulses are emitted. The holding register and `rx_valid` are preserved.
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0, state IDLE, `shreg`=0.
- **`rst` mid-frame:** everything returns to reset values on the next edge, and any partial byte is lost.

## Timing
- Pad to `rx_s` is 2 clocks. Start detection happens in the cycle where `rx_s==0` and `rx_d==1` (cycle D).
- `rx_valid` rises at cycle D + 154·(`baud_div`+1) + 1. The 154 ticks are 9 full bits plus 10 samples of the stop bit.
- `frame_err` and `overrun` pulse in the same cycle the delivery would have set `rx_valid`.
- The receiver is back in IDLE roughly 6 ticks before the nominal stop-bit end, so back-to-back frames with a 1-stop-bit gap are received.
- `baud_div`=0 is legal: 16 clocks per bit.
- `baud_div` must be held constant while `busy` is high; behaviour is undefined otherwise.
- `busy` is a registered decode of state (high whenever the FSM is not in IDLE), with no combinational path from `rx`.

## Test plan
- **Single byte:** `baud_div`=3 (64 clocks/bit), send 0xA5 as 8N1 with `rx_ready`=1. Expect a single `rx_valid` cycle at D+617 with `rx_data`=0xA5, and no error pulses.
- **Glitch rejection:** drive a 20-clock low pulse on an idle line. Expect `busy` high then low, and no `rx_valid` or `frame_err`.
- **Framing error:** send 0x3C with the stop bit driven low. Expect a `frame_err` pulse at D+617, `rx_valid` to stay 0, and no new frame until the line goes high and falls again.
- **Overrun:** with `rx_ready`=0, send 0x11 then 0x22. Expect 0x11 held, `rx_valid`=1, and an `overrun` pulse at the second delivery. Raising `rx_ready` returns 0x11, then `rx_valid` goes 0.
- **Simultaneous ready and delivery:** 0x55 is pending, and `rx_ready`=1 exactly in the cycle 0xAA completes. Expect no `overrun`, `rx_valid` to stay 1, and `rx_data`=0xAA.
- **Reset and `en` mid-frame:** assert `rst` during bit 4. All outputs must be at reset values next cycle, and a following 0xF0 must be received correctly. Repeat with `en` low: the frame is aborted and the pending holding register is kept.
